// File: rtl/mem_dp_be.sv
// Simple dual-port word memory with per-lane write enables, range checking,
// selectable read-during-write behaviour and a 1- or 2-cycle registered read.
module mem_dp_be #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int MAX_ADR    = 100,
  parameter int ADDRSIZE   = $clog2(MAX_ADR),
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             rd_en,
  input  logic [ADDRSIZE-1:0]              rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid,
  output logic                             rd_err,
  input  logic                             wr_en,
  input  logic [ADDRSIZE-1:0]              wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
  output logic                             wr_err
);

  localparam int NUM_LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDRSIZE:0] MAX_ADR_L = MAX_ADR[ADDRSIZE:0];

  generate
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
      $error("mem_dp_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
      $error("mem_dp_be: RD_LATENCY must be 1 or 2");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [MAX_ADR];

  logic                  rd_in_range;
  logic                  wr_in_range;
  logic                  wr_hit;
  logic [DATA_WIDTH-1:0] mem_word;
  logic [DATA_WIDTH-1:0] rd_word;

  assign rd_in_range = ({1'b0, rd_addr} < MAX_ADR_L);
  assign wr_in_range = ({1'b0, wr_addr} < MAX_ADR_L);
  assign wr_hit      = (RDW_MODE == 1) && wr_en && wr_in_range && (wr_addr == rd_addr);

  // Contents are deliberately never reset; rst_n only blocks writes.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en && wr_in_range) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_comb begin
    mem_word = '0;
    if (rd_in_range) begin
      mem_word = mem[rd_addr];
    end
  end

  // New-data mode forwards the enabled write lanes over the stored word.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign rd_word[gi*BYTE_WIDTH +: BYTE_WIDTH] = (wr_hit && wr_be[gi])
          ? wr_data[gi*BYTE_WIDTH +: BYTE_WIDTH]
          : mem_word[gi*BYTE_WIDTH +: BYTE_WIDTH];
    end
  endgenerate

  logic                  s1_valid_reg;
  logic                  s1_err_reg;
  logic [DATA_WIDTH-1:0] s1_data_reg;
  logic                  wr_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_err_reg   <= 1'b0;
      s1_data_reg  <= '0;
      wr_err_reg   <= 1'b0;
    end else begin
      s1_valid_reg <= rd_en;
      s1_err_reg   <= rd_en && !rd_in_range;
      if (rd_en) begin
        s1_data_reg <= rd_word;
      end
      wr_err_reg <= wr_en && (|wr_be) && !wr_in_range;
    end
  end

  assign wr_err = wr_err_reg;

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  s2_valid_reg;
      logic                  s2_err_reg;
      logic [DATA_WIDTH-1:0] s2_data_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_valid_reg <= 1'b0;
          s2_err_reg   <= 1'b0;
          s2_data_reg  <= '0;
        end else begin
          s2_valid_reg <= s1_valid_reg;
          s2_err_reg   <= s1_valid_reg && s1_err_reg;
          if (s1_valid_reg) begin
            s2_data_reg <= s1_data_reg;
          end
        end
      end

      assign rd_valid = s2_valid_reg;
      assign rd_err   = s2_err_reg;
      assign rd_data  = s2_data_reg;
    end else begin : g_lat1
      assign rd_valid = s1_valid_reg;
      assign rd_err   = s1_err_reg;
      assign rd_data  = s1_data_reg;
    end
  endgenerate

endmodule

// File: doc/mem_dp_be.md
MEM_DP_BE -- requirements
Module: mem_dp_be

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the word width in bits.
REQ-002 The block SHALL have parameter BYTE_WIDTH, default 8, giving the write-enable lane width in bits.
REQ-003 The block SHALL have parameter MAX_ADR, default 100, giving the number of words (valid addresses 0..MAX_ADR-1).
REQ-004 The block SHALL have parameter ADDRSIZE, default $clog2(MAX_ADR), giving the address width.
REQ-005 The block SHALL have parameter RD_LATENCY, default 1, giving the read latency in cycles; legal values are 1 or 2.
REQ-006 The block SHALL have parameter RDW_MODE, default 0, giving same-address read-during-write data: 0 = old data, 1 = new (merged) data.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 The block SHALL have port rd_en, input, 1 bit: read request, sampled on the rising edge.
REQ-010 The block SHALL have port rd_addr, input, ADDRSIZE bits: read address.
REQ-011 The block SHALL have port rd_data, output, DATA_WIDTH bits: read data, registered.
REQ-012 The block SHALL have port rd_valid, output, 1 bit: one-cycle pulse marking rd_data as valid.
REQ-013 The block SHALL have port rd_err, output, 1 bit: out-of-range read, qualified by rd_valid.
REQ-014 The block SHALL have port wr_en, input, 1 bit: write request.
REQ-015 The block SHALL have port wr_addr, input, ADDRSIZE bits: write address.
REQ-016 The block SHALL have port wr_data, input, DATA_WIDTH bits: write data.
REQ-017 The block SHALL have port wr_be, input, DATA_WIDTH/BYTE_WIDTH bits: per-lane write enable; bit i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH].
REQ-018 The block SHALL have port wr_err, output, 1 bit: one-cycle pulse on an out-of-range write.

Function
REQ-019 Elaboration SHALL fail if DATA_WIDTH is not a multiple of BYTE_WIDTH, or if RD_LATENCY is not 1 or 2.
REQ-020 On an edge with wr_en=1 and wr_addr<MAX_ADR, only the lanes with wr_be[i]=1 SHALL update; the other lanes are unchanged.
REQ-021 wr_en=1 with wr_be=0 SHALL change nothing and SHALL NOT raise wr_err.
REQ-022 wr_en=1 with wr_addr>=MAX_ADR SHALL write nothing and SHALL pulse wr_err for the one cycle after that edge.
REQ-023 A read accepted at edge N (rd_en=1) SHALL present rd_data/rd_valid=1 after edge N+RD_LATENCY-1, for exactly one cycle of rd_valid.
REQ-024 Back-to-back reads SHALL be accepted every cycle, giving full throughput and in-order results at both latencies.
REQ-025 While no read is completing, rd_valid SHALL be 0 and rd_data SHALL hold its last value.
REQ-026 A read with rd_addr>=MAX_ADR SHALL return rd_data=0 and rd_err=1 with rd_valid=1; rd_err is 0 on every other cycle.
REQ-027 A read and a write on the same edge at different addresses SHALL both complete.
REQ-028 Same edge and same in-range address with RDW_MODE=0: rd_data SHALL return the contents before the write.
REQ-029 Same edge and same address with RDW_MODE=1: rd_data SHALL return wr_data on enabled lanes and old contents on the other lanes.
REQ-030 A write on edge N SHALL be visible to any read accepted on edge N+1 or later, at both latencies.

Reset
REQ-031 While rst_n=0, outputs SHALL be rd_data=0, rd_valid=0, rd_err=0, wr_err=0, and the latency-2 pipeline stage SHALL be cleared, all immediately and asynchronously.
REQ-032 While rst_n=0, reads and writes SHALL be ignored.
REQ-033 Memory contents SHALL NOT be reset; they are retained across reset.
REQ-034 A read in flight when reset asserts SHALL be discarded, with no rd_valid after release.
REQ-035 The first accepted request SHALL be on the first rising edge with rst_n=1.

Verification
REQ-036 The bench SHALL cover byte-lane write: write 0xAABBCCDD to addr 5 with be=1111, then 0x11223344 with be=0101; read addr 5 -> 0xAA22CC44, rd_valid for 1 cycle.
REQ-037 The bench SHALL cover latency: with RD_LATENCY=2, reads to addr 0,1,2 on three consecutive edges -> three consecutive rd_valid pulses, starting 2 edges after the first request, data in order.
REQ-038 The bench SHALL cover collision: addr 7 holds 0x00000000; on one edge write 0xFFFFFFFF be=0011 and read addr 7 -> RDW_MODE=0 returns 0x00000000, RDW_MODE=1 returns 0x0000FFFF; a later read returns 0x0000FFFF.
REQ-039 The bench SHALL cover range errors: write to addr 100 -> wr_err pulse, memory unchanged; read addr 120 -> rd_data=0, rd_err=1, rd_valid=1.
REQ-040 The bench SHALL cover reset mid-read: with RD_LATENCY=2, issue a read, then assert rst_n=0 between edges -> outputs 0 immediately; after release no rd_valid; a prior write to addr 3 is still readable.
REQ-041 The bench SHALL cover an empty write: wr_en=1, be=0000, addr 4 -> addr 4 contents unchanged and wr_err=0.
